// File: rtl/bpu_update_ctrl_pkg.sv
// Shared types for the branch-resolution / predictor-update path.
package bpu_update_ctrl_pkg;

  localparam int unsigned GSHARE_GHSR_WIDTH = 8;

  typedef struct packed {
    logic [31:0]                  pc;
    logic [31:0]                  target;
    logic                         taken;
    logic [GSHARE_GHSR_WIDTH-1:0] ghsr;
  } bpu_upd_t;

  typedef enum logic {
    RUN   = 1'b0,
    FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bpu_upd_fifo.sv
// Synchronous FIFO of predictor updates; pointers carry an extra wrap bit.
module bpu_upd_fifo
  import bpu_update_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  bpu_upd_t               push_data_i,
  input  logic                   pop_i,
  output bpu_upd_t               head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  bpu_upd_t    mem_q [DEPTH];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/bpu_update_ctrl.sv
// Branch-resolution scheduler: registered redirect/flush/GHSR restore plus
// queued predictor training with a starvation-bounded port arbiter.
module bpu_update_ctrl
  import bpu_update_ctrl_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned STARVE_MAX  = 3,
  parameter int unsigned GHSR_W      = GSHARE_GHSR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ex_valid,
  input  logic                         ex_taken,
  input  logic                         ex_mispred,
  input  logic [31:0]                  ex_instr_pc,
  input  logic [31:0]                  ex_target,
  input  logic                         ex_is_compressed,
  input  logic [GHSR_W-1:0]            ex_ghsr,
  output logic                         ex_stall,
  output logic                         redirect_valid,
  output logic [31:0]                  redirect_pc,
  output logic                         flush,
  output logic                         ghsr_restore_valid,
  output logic [GHSR_W-1:0]            ghsr_restore,
  input  logic                         if_lookup_req,
  output logic                         if_hold,
  output logic                         upd_valid,
  output logic [31:0]                  upd_pc,
  output logic [31:0]                  upd_target,
  output logic                         upd_taken,
  output logic [GHSR_W-1:0]            upd_ghsr,
  output logic [$clog2(QUEUE_DEPTH):0] q_count
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam arb_state_e ARB_RST = (STARVE_MAX == 0) ? FORCE : RUN;

  logic       fifo_full, fifo_empty, accept, mispred_acc;
  bpu_upd_t   push_ent, head_ent;

  assign ex_stall    = fifo_full;
  assign accept      = ex_valid && !fifo_full;
  assign mispred_acc = accept && ex_mispred;

  // History is stored at package width; GHSR_W must not exceed it.
  assign push_ent = '{pc:     ex_instr_pc,
                      target: ex_target,
                      taken:  ex_taken,
                      ghsr:   GSHARE_GHSR_WIDTH'(ex_ghsr)};

  bpu_upd_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (accept),
    .push_data_i (push_ent),
    .pop_i       (upd_valid),
    .head_o      (head_ent),
    .count_o     (q_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign upd_pc     = fifo_empty ? '0 : head_ent.pc;
  assign upd_target = fifo_empty ? '0 : head_ent.target;
  assign upd_taken  = fifo_empty ? 1'b0 : head_ent.taken;
  assign upd_ghsr   = fifo_empty ? '0 : GHSR_W'(head_ent.ghsr);

  // Starvation arbiter: FORCE mirrors starve == STARVE_MAX.
  arb_state_e    arb_q, arb_d;
  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d  = starve_q;
    upd_valid = !fifo_empty && (!if_lookup_req || (arb_q == FORCE));
    if_hold   = !fifo_empty && if_lookup_req && (arb_q == FORCE);
    if (fifo_empty || upd_valid) starve_d = '0;
    else if (starve_q != SMAX)   starve_d = starve_q + 1'b1;
    arb_d = (starve_d == SMAX) ? FORCE : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_q    <= ARB_RST;
      starve_q <= '0;
    end else begin
      arb_q    <= arb_d;
      starve_q <= starve_d;
    end
  end

  logic              redirect_valid_q, flush_q, ghsr_restore_valid_q;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic [GHSR_W-1:0] ghsr_restore_q, ghsr_restore_d;

  always_comb begin
    redirect_pc_d  = ex_taken ? ex_target
                              : ex_instr_pc + (ex_is_compressed ? 32'd2 : 32'd4);
    ghsr_restore_d = {ex_ghsr[GHSR_W-2:0], ex_taken};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q     <= 1'b0;
      flush_q              <= 1'b0;
      ghsr_restore_valid_q <= 1'b0;
      redirect_pc_q        <= '0;
      ghsr_restore_q       <= '0;
    end else begin
      redirect_valid_q     <= mispred_acc;
      flush_q              <= mispred_acc;
      ghsr_restore_valid_q <= mispred_acc;
      if (mispred_acc) begin
        redirect_pc_q  <= redirect_pc_d;
        ghsr_restore_q <= ghsr_restore_d;
      end
    end
  end

  assign redirect_valid     = redirect_valid_q;
  assign flush              = flush_q;
  assign ghsr_restore_valid = ghsr_restore_valid_q;
  assign redirect_pc        = redirect_pc_q;
  assign ghsr_restore       = ghsr_restore_q;

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Self-checking bench for bpu_update_ctrl: queue-based reference model plus
// directed literal checks from the branch-resolution scenarios.
module tb_bpu_update_ctrl;

  localparam int unsigned D    = 4;
  localparam int unsigned SMAX = 3;
  localparam int unsigned W    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_taken, ex_mispred, ex_is_compressed, if_lookup_req;
  logic [31:0] ex_instr_pc, ex_target;
  logic [W-1:0] ex_ghsr;
  logic        ex_stall, redirect_valid, flush, ghsr_restore_valid, if_hold;
  logic        upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [W-1:0] ghsr_restore, upd_ghsr;
  logic [2:0]  q_count;

  bpu_update_ctrl #(.QUEUE_DEPTH(D), .STARVE_MAX(SMAX), .GHSR_W(W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_mispred(ex_mispred),
    .ex_instr_pc(ex_instr_pc), .ex_target(ex_target),
    .ex_is_compressed(ex_is_compressed), .ex_ghsr(ex_ghsr),
    .ex_stall(ex_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .ghsr_restore_valid(ghsr_restore_valid), .ghsr_restore(ghsr_restore),
    .if_lookup_req(if_lookup_req), .if_hold(if_hold),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_ghsr(upd_ghsr), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: queue of entries, starvation count, pending redirect.
  typedef struct {
    logic [31:0]  pc;
    logic [31:0]  tgt;
    logic         tk;
    logic [W-1:0] gh;
  } ent_t;

  ent_t        mq[$];
  int          m_starve = 0;
  bit          m_rv = 0;
  logic [31:0] m_rpc = '0;
  logic [W-1:0] m_rgh = '0;
  bit          chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit   m_empty, m_full, m_uv, m_hold, acc;
      ent_t e;
      m_empty = (mq.size() == 0);
      m_full  = (mq.size() == D);
      m_uv    = !m_empty && (!if_lookup_req || m_starve == SMAX);
      m_hold  = !m_empty && if_lookup_req && (m_starve == SMAX);
      e = '{pc: 32'h0, tgt: 32'h0, tk: 1'b0, gh: '0};
      if (!m_empty) e = mq[0];

      chk("ex_stall", {31'd0, ex_stall}, {31'd0, m_full});
      chk("q_count", {29'd0, q_count}, mq.size());
      chk("upd_valid", {31'd0, upd_valid}, {31'd0, m_uv});
      chk("if_hold", {31'd0, if_hold}, {31'd0, m_hold});
      chk("upd_pc", upd_pc, e.pc);
      chk("upd_target", upd_target, e.tgt);
      chk("upd_taken", {31'd0, upd_taken}, {31'd0, e.tk});
      chk("upd_ghsr", {28'd0, upd_ghsr}, {28'd0, e.gh});
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
      chk("flush", {31'd0, flush}, {31'd0, m_rv});
      chk("ghsr_restore_valid", {31'd0, ghsr_restore_valid}, {31'd0, m_rv});
      if (m_rv) begin
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("ghsr_restore", {28'd0, ghsr_restore}, {28'd0, m_rgh});
      end

      if (rst) begin
        mq.delete();
        m_starve = 0;
        m_rv     = 0;
      end else begin
        acc  = ex_valid && !m_full;
        m_rv = acc && ex_mispred;
        if (m_rv) begin
          m_rpc = ex_taken ? ex_target : ex_instr_pc + (ex_is_compressed ? 2 : 4);
          m_rgh = W'((ex_ghsr << 1) | W'(ex_taken));
        end
        if (m_empty || m_uv) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        if (m_uv) void'(mq.pop_front());
        if (acc) mq.push_back('{pc: ex_instr_pc, tgt: ex_target, tk: ex_taken, gh: ex_ghsr});
      end
    end
  end

  task automatic drive(input logic v, input logic tk, input logic mis,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic comp, input logic [W-1:0] gh, input logic req);
    ex_valid = v; ex_taken = tk; ex_mispred = mis; ex_instr_pc = pc;
    ex_target = tgt; ex_is_compressed = comp; ex_ghsr = gh; if_lookup_req = req;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 32'h0, 32'h0, 0, '0, 0);
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0, 0, '0, 0);
    step();
    chk_en = 1;
    step();
    @(negedge clk);
    chk("rst q_count", {29'd0, q_count}, 32'd0);
    chk("rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst upd_valid", {31'd0, upd_valid}, 32'd0);
    step();
    rst = 1'b0;

    // Not-taken mispredict, then starvation of its queued entry.
    drive(1, 0, 1, 32'h100, 32'h500, 0, 4'b1011, 1);
    step();
    drive(0, 0, 0, 32'h0, 32'h0, 0, '0, 1);
    @(negedge clk);
    chk("nt redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("nt redirect_pc", redirect_pc, 32'h104);
    chk("nt ghsr_restore", {28'd0, ghsr_restore}, 32'b0110);
    chk("nt flush", {31'd0, flush}, 32'd1);
    chk("starve c1 upd_valid", {31'd0, upd_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("nt flush one cycle", {31'd0, flush}, 32'd0);
    chk("starve c2 upd_valid", {31'd0, upd_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("starve c3 upd_valid", {31'd0, upd_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("starve c4 upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("starve c4 if_hold", {31'd0, if_hold}, 32'd1);
    chk("starve c4 upd_pc", upd_pc, 32'h100);
    step();
    @(negedge clk);
    chk("starve c5 q_count", {29'd0, q_count}, 32'd0);

    // Back-to-back mispredicts: taken compressed, not-taken compressed, pc wrap.
    idle(2);
    drive(1, 1, 1, 32'h2FE, 32'h400, 1, 4'b0001, 0);
    step();
    drive(1, 0, 1, 32'h2FE, 32'h400, 1, 4'b0001, 0);
    @(negedge clk);
    chk("tk redirect_pc", redirect_pc, 32'h400);
    step();
    drive(1, 0, 1, 32'hFFFF_FFFE, 32'h0, 1, 4'b1000, 0);
    @(negedge clk);
    chk("b2b redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("ntc redirect_pc", redirect_pc, 32'h300);
    step();
    drive(0, 0, 0, 32'h0, 32'h0, 0, '0, 0);
    @(negedge clk);
    chk("wrap redirect_pc", redirect_pc, 32'h0);
    chk("wrap ghsr_restore", {28'd0, ghsr_restore}, 32'b0000);

    // Fill the queue while IF holds the port; 5th branch must be ignored.
    idle(4);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 32'h1000 + 32'(i * 4), 32'h2000, 0, 4'(i), 1);
      step();
    end
    drive(1, 1, 1, 32'h3000, 32'h3100, 0, 4'hF, 1);
    @(negedge clk);
    chk("full ex_stall", {31'd0, ex_stall}, 32'd1);
    chk("full q_count", {29'd0, q_count}, 32'd4);
    step();
    drive(0, 0, 0, 32'h0, 32'h0, 0, '0, 1);
    @(negedge clk);
    chk("full 5th no redirect", {31'd0, redirect_valid}, 32'd0);
    chk("full after force pop", {29'd0, q_count}, 32'd3);

    // Reset mid-operation with three entries and a pending mispredict.
    idle(8);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 32'h4000 + 32'(i * 2), 32'h0, 1, 4'(i), 1);
      step();
    end
    drive(1, 1, 1, 32'h5000, 32'h6000, 0, 4'h3, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0, 0, '0, 1);
    @(negedge clk);
    chk("midrst q_count", {29'd0, q_count}, 32'd0);
    chk("midrst redirect_valid", {31'd0, redirect_valid}, 32'd0);

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | ($urandom & 32'h6)) : ($urandom & ~32'h1);
      drive($urandom_range(0, 9) < 6, 1'($urandom), $urandom_range(0, 9) < 3, pc,
            $urandom & ~32'h1, 1'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
